// File: rtl/writeback_queue_if.sv
// Handshake and write-port bundle between the producers, register file and the writeback queue.
// Signal names follow the register-file port naming used by the surrounding pipeline.
interface writeback_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_rw;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_rw;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              reg_write;
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] busW;
    logic [ADDR_W-1:0] qa;
    logic [ADDR_W-1:0] qb;
    logic              hit_a;
    logic [DATA_W-1:0] fwd_a;
    logic              hit_b;
    logic [DATA_W-1:0] fwd_b;
    logic [CW-1:0]     count;

    modport slave (
        input  mem_valid, mem_rw, mem_data,
        input  alu_valid, alu_rw, alu_data,
        input  qa, qb,
        output mem_ready, alu_ready,
        output reg_write, rw, busW,
        output hit_a, fwd_a, hit_b, fwd_b,
        output count
    );

    modport master (
        output mem_valid, mem_rw, mem_data,
        output alu_valid, alu_rw, alu_data,
        output qa, qb,
        input  mem_ready, alu_ready,
        input  reg_write, rw, busW,
        input  hit_a, fwd_a, hit_b, fwd_b,
        input  count
    );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: merges ALU and load results and drains one per cycle into the register file.
// Optional WBQ_ZERO_FILTER_EN drops results destined for register 0 and hides them from forwarding.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RST,
    writeback_queue_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] LIM1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] LIM2 = CW'(DEPTH - 2);

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [ADDR_W-1:0] rw_q [DEPTH];
    logic [DATA_W-1:0] dat_q [DEPTH];

    logic          pop;
    logic          mem_rdy, alu_rdy;
    logic          mem_push, alu_push;
    logic          mem_enq, alu_enq;
    logic          qa_ok, qb_ok;
    logic [PW-1:0] alu_slot;

    assign pop     = (count_q != '0);
    assign mem_rdy = (count_q <= LIM1);
    assign alu_rdy = bus.mem_valid ? (count_q <= LIM2) : (count_q <= LIM1);

    assign mem_push = bus.mem_valid && mem_rdy;
    assign alu_push = bus.alu_valid && alu_rdy;

`ifdef WBQ_ZERO_FILTER_EN
    assign mem_enq = mem_push && (bus.mem_rw != '0);
    assign alu_enq = alu_push && (bus.alu_rw != '0);
    assign qa_ok   = (bus.qa != '0);
    assign qb_ok   = (bus.qb != '0);
`else
    assign mem_enq = mem_push;
    assign alu_enq = alu_push;
    assign qa_ok   = 1'b1;
    assign qb_ok   = 1'b1;
`endif

    // The load result is the older instruction, so it takes the first free slot.
    assign alu_slot = tail_q + PW'(mem_enq);

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(mem_enq) + PW'(alu_enq);
        count_d = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(pop);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_enq) begin
            rw_q[tail_q]  <= bus.mem_rw;
            dat_q[tail_q] <= bus.mem_data;
        end
        if (alu_enq) begin
            rw_q[alu_slot]  <= bus.alu_rw;
            dat_q[alu_slot] <= bus.alu_data;
        end
    end

    assign bus.mem_ready = mem_rdy;
    assign bus.alu_ready = alu_rdy;
    assign bus.reg_write = pop;
    assign bus.rw        = pop ? rw_q[head_q] : '0;
    assign bus.busW      = pop ? dat_q[head_q] : '0;
    assign bus.count     = count_q;

    logic              hit_a, hit_b;
    logic [DATA_W-1:0] fwd_a, fwd_b;
    logic [PW-1:0]     idx;

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        fwd_a = '0;
        fwd_b = '0;
        idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if (qa_ok && rw_q[idx] == bus.qa) begin
                    hit_a = 1'b1;
                    fwd_a = dat_q[idx];
                end
                if (qb_ok && rw_q[idx] == bus.qb) begin
                    hit_b = 1'b1;
                    fwd_b = dat_q[idx];
                end
            end
        end
    end

    assign bus.hit_a = hit_a;
    assign bus.fwd_a = fwd_a;
    assign bus.hit_b = hit_b;
    assign bus.fwd_b = fwd_b;
endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: reference queue model plus an in-order write scoreboard.
// Honours WBQ_ZERO_FILTER_EN the same way the design does.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] d;
    } ent_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ent_t mq[$];
    ent_t exp_q[$];
    ent_t mon_e;

    writeback_queue_if #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) bus ();

    writeback_queue #(.DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic bit enq_ok(input logic [4:0] r);
`ifdef WBQ_ZERO_FILTER_EN
        return r != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_fwd(input logic [4:0] q, output bit h,
                                      output logic [31:0] d);
        h = 1'b0;
        d = '0;
`ifdef WBQ_ZERO_FILTER_EN
        if (q == 5'd0) return;
`endif
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].rw == q) begin
                h = 1'b1;
                d = mq[i].d;
            end
    endfunction

    // In-order write scoreboard: each observed write must be the oldest accepted result.
    always @(posedge CLK) begin
        #1;
        if (bus.reg_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected actual rw=%h busW=%h required no write",
                         bus.rw, bus.busW);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_rw", 32'(bus.rw), 32'(mon_e.rw));
                chk("wr_busW", bus.busW, mon_e.d);
            end
        end
    end

    task automatic cyc(input bit rst, input bit mv, input logic [4:0] mrw,
                       input logic [31:0] md, input bit av,
                       input logic [4:0] arw, input logic [31:0] ad,
                       input logic [4:0] a, input logic [4:0] b);
        int   n;
        bit   mr, ar, h;
        logic [31:0] d;
        @(negedge CLK);
        RST = rst;
        bus.mem_valid = mv;
        bus.mem_rw = mrw;
        bus.mem_data = md;
        bus.alu_valid = av;
        bus.alu_rw = arw;
        bus.alu_data = ad;
        bus.qa = a;
        bus.qb = b;
        #1;
        n  = mq.size();
        mr = (n < DEPTH);
        ar = mv ? (n < DEPTH - 1) : (n < DEPTH);
        chk("count", 32'(bus.count), 32'(n));
        chk("reg_write", 32'(bus.reg_write), 32'(n != 0));
        chk("rw", 32'(bus.rw), n != 0 ? 32'(mq[0].rw) : 32'd0);
        chk("busW", bus.busW, n != 0 ? mq[0].d : 32'd0);
        chk("mem_ready", 32'(bus.mem_ready), 32'(mr));
        chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
        model_fwd(a, h, d);
        chk("hit_a", 32'(bus.hit_a), 32'(h));
        chk("fwd_a", bus.fwd_a, d);
        model_fwd(b, h, d);
        chk("hit_b", 32'(bus.hit_b), 32'(h));
        chk("fwd_b", bus.fwd_b, d);
        @(posedge CLK);
        if (rst) begin
            mq.delete();
            exp_q.delete();
        end else begin
            if (n != 0) void'(mq.pop_front());
            if (mv && mr && enq_ok(mrw)) begin
                mq.push_back('{mrw, md});
                exp_q.push_back('{mrw, md});
            end
            if (av && ar && enq_ok(arw)) begin
                mq.push_back('{arw, ad});
                exp_q.push_back('{arw, ad});
            end
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.mem_valid = 0;
        bus.mem_rw = 0;
        bus.mem_data = 0;
        bus.alu_valid = 0;
        bus.alu_rw = 0;
        bus.alu_data = 0;
        bus.qa = 0;
        bus.qb = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_reg_write", 32'(bus.reg_write), 0);
        chk("rst_rw", 32'(bus.rw), 0);
        chk("rst_busW", bus.busW, 0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 1);

        cyc(0, 0, 0, 0, 1, 5, 32'hAA, 5, 0);
        idle(2);
        cyc(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
        idle(3);
        cyc(0, 1, 7, 32'h10, 1, 7, 32'h20, 7, 8);
        cyc(0, 0, 0, 0, 0, 0, 0, 7, 8);
        idle(2);
        cyc(0, 0, 0, 0, 1, 0, 32'hFF, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 5'(8 + i), 32'(16 + i), 1, 5'(12 + i), 32'(32 + i), 8, 12);
        idle(6);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 5'(1 + i), 32'(64 + i), 1, 5'(4 + i), 32'(96 + i), 1, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_mid_count", 32'(bus.count), 0);
        chk("rst_mid_reg_write", 32'(bus.reg_write), 0);
        idle(4);

        for (int i = 0; i < 600; i++)
            cyc(($urandom % 64) == 0, ($urandom % 3) != 0, 5'($urandom % 8),
                $urandom, ($urandom % 3) != 0, 5'($urandom % 8), $urandom,
                5'($urandom % 8), 5'($urandom % 8));
        idle(8);
        #2;
        chk("exp_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
